// File: rtl/status_register_unit_pkg.sv
// Shared status-flag definitions for the ALU status path and branch logic.
// Flag bit positions and the ALU operation class encoding.
package status_register_unit_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_LOGIC = 2'd2,
        OP_SHIFT = 2'd3
    } op_class_e;

    function automatic logic add_ovf(
        input logic a,
        input logic b,
        input logic r
    );
        return (a == b) && (r != a);
    endfunction

    function automatic logic sub_ovf(
        input logic a,
        input logic b,
        input logic r
    );
        return (a != b) && (r != a);
    endfunction

endpackage

// File: rtl/status_register_unit_if.sv
// Bundle between the execute stage and the status register unit.
// The master drives ALU results and control strobes; the slave returns flags.
interface status_register_unit_if #(
    parameter int WORD_W = 16
);
    import status_register_unit_pkg::*;

    logic                flag_upd;
    logic [FLAG_W-1:0]   flag_mask;
    op_class_e           op_class;
    logic                byte_mode;
    logic [WORD_W-1:0]   op_a;
    logic [WORD_W-1:0]   op_b;
    logic [WORD_W-1:0]   result;
    logic                alu_carry;
    logic                shift_out;
    logic                psw_wr;
    logic [FLAG_W-1:0]   psw_wdata;
    logic                push;
    logic                pop;
    logic                err_clr;
    logic [FLAG_W-1:0]   status;
    logic                shadow_full;
    logic                shadow_empty;
    logic                err_ovf;
    logic                err_unf;

    modport master (
        output flag_upd, flag_mask, op_class, byte_mode,
        output op_a, op_b, result, alu_carry, shift_out,
        output psw_wr, psw_wdata, push, pop, err_clr,
        input  status, shadow_full, shadow_empty,
        input  err_ovf, err_unf
    );

    modport slave (
        input  flag_upd, flag_mask, op_class, byte_mode,
        input  op_a, op_b, result, alu_carry, shift_out,
        input  psw_wr, psw_wdata, push, pop, err_clr,
        output status, shadow_full, shadow_empty,
        output err_ovf, err_unf
    );

endinterface

// File: rtl/status_shadow_stack.sv
// LIFO of saved status words with sticky overflow/underflow indicators.
// A simultaneous push and pop is rejected as both an overflow and an underflow.
module status_shadow_stack
    import status_register_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    input  logic [FLAG_W-1:0] wr_data,
    output logic [FLAG_W-1:0] rd_data,
    output logic              pop_ok,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]     count_q;
    logic [FLAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              both;
    logic              set_ovf;
    logic              set_unf;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign both    = push & pop;
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign set_ovf = both | (push & full);
    assign set_unf = both | (pop & empty);

    // A full stack wraps wr_ptr to 0, so rd_ptr still lands on the top entry.
    assign wr_ptr  = count_q[AW-1:0];
    assign rd_ptr  = wr_ptr - AW'(1);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (push_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok) begin
                count_q <= count_q - CW'(1);
            end
            ovf <= set_ovf | (ovf & ~err_clr);
            unf <= set_unf | (unf & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/status_register_unit.sv
// Processor status word: ALU flag generation, direct load and save/restore.
// Load priority is direct write, then restore, then ALU flag update.
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int SHADOW_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    status_register_unit_if.slave bus
);
    logic [FLAG_W-1:0] status_q;
    logic [FLAG_W-1:0] status_d;
    logic [FLAG_W-1:0] calc;
    logic [FLAG_W-1:0] upd;
    logic [FLAG_W-1:0] shadow_data;
    logic              pop_ok;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;
    logic              r_zero;

    status_shadow_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.push),
        .pop     (bus.pop),
        .err_clr (bus.err_clr),
        .wr_data (status_q),
        .rd_data (shadow_data),
        .pop_ok  (pop_ok),
        .full    (bus.shadow_full),
        .empty   (bus.shadow_empty),
        .ovf     (bus.err_ovf),
        .unf     (bus.err_unf)
    );

    always_comb begin
        a_msb  = bus.byte_mode ? bus.op_a[7]   : bus.op_a[WORD_W-1];
        b_msb  = bus.byte_mode ? bus.op_b[7]   : bus.op_b[WORD_W-1];
        r_msb  = bus.byte_mode ? bus.result[7] : bus.result[WORD_W-1];
        r_zero = bus.byte_mode ? ~|bus.result[7:0] : ~|bus.result;

        calc         = status_q;
        calc[FLAG_N] = r_msb;
        calc[FLAG_Z] = r_zero;
        unique case (bus.op_class)
            OP_ADD: begin
                calc[FLAG_C] = bus.alu_carry;
                calc[FLAG_V] = add_ovf(a_msb, b_msb, r_msb);
            end
            OP_SUB: begin
                calc[FLAG_C] = bus.alu_carry;
                calc[FLAG_V] = sub_ovf(a_msb, b_msb, r_msb);
            end
            OP_SHIFT: begin
                calc[FLAG_C] = bus.shift_out;
                calc[FLAG_V] = 1'b0;
            end
            default: ;
        endcase

        // LOGIC leaves calc C/V at the held value, so the mask cannot move them.
        upd = status_q;
        for (int i = 0; i < FLAG_W; i++) begin
            if (bus.flag_mask[i]) upd[i] = calc[i];
        end

        status_d = status_q;
        if (bus.psw_wr) begin
            status_d = bus.psw_wdata;
        end else if (pop_ok) begin
            status_d = shadow_data;
        end else if (bus.flag_upd) begin
            status_d = upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status = status_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed self-checking bench for the status register unit.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_status_register_unit;
    import status_register_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    status_register_unit_if #(.WORD_W(16)) bus ();

    status_register_unit #(
        .WORD_W       (16),
        .SHADOW_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flag_upd  = 1'b0;
        bus.flag_mask = 4'h0;
        bus.op_class  = OP_ADD;
        bus.byte_mode = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.result    = '0;
        bus.alu_carry = 1'b0;
        bus.shift_out = 1'b0;
        bus.psw_wr    = 1'b0;
        bus.psw_wdata = 4'h0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alu(input op_class_e op, input logic bm,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic cy,
                       input logic so, input logic [3:0] m);
        bus.flag_upd  = 1'b1;
        bus.op_class  = op;
        bus.byte_mode = bm;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.result    = r;
        bus.alu_carry = cy;
        bus.shift_out = so;
        bus.flag_mask = m;
    endtask

    task automatic psw(input logic [3:0] v);
        bus.psw_wr    = 1'b1;
        bus.psw_wdata = v;
    endtask

    task automatic occ(input string tag, input logic f, input logic e);
        chk({tag, "_full"}, {3'b0, bus.shadow_full}, {3'b0, f});
        chk({tag, "_empty"}, {3'b0, bus.shadow_empty}, {3'b0, e});
    endtask

    task automatic errs(input string tag, input logic o, input logic u);
        chk({tag, "_ovf"}, {3'b0, bus.err_ovf}, {3'b0, o});
        chk({tag, "_unf"}, {3'b0, bus.err_unf}, {3'b0, u});
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_status", bus.status, 4'h0);
        occ("rst", 1'b0, 1'b1);
        errs("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // word ADD signed overflow; status must not move before the edge
        alu(OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 4'hF);
        #1 chk("add_pre_edge", bus.status, 4'h0);
        step();
        chk("add_word_ovf", bus.status, 4'hC);

        // byte SUB: upper byte of result ignored
        alu(OP_SUB, 1'b1, 16'h3405, 16'h7705, 16'hAB00, 1'b1, 1'b0, 4'hF);
        step();
        chk("sub_byte_zero", bus.status, 4'h3);

        psw(4'hD);
        step();
        chk("psw_load", bus.status, 4'hD);
        alu(OP_LOGIC, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'hF);
        step();
        chk("logic_hold_cv", bus.status, 4'hB);

        alu(OP_ADD, 1'b0, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0, 4'h2);
        step();
        chk("mask_z_only", bus.status, 4'h9);
        alu(OP_SHIFT, 1'b0, 16'h4000, 16'h0001, 16'h8000, 1'b0, 1'b1, 4'hF);
        step();
        chk("shift_flags", bus.status, 4'h5);

        // push stores the pre-edge status while psw_wr still loads
        psw(4'h1);
        step();
        bus.push = 1'b1; psw(4'h2);
        step();
        chk("push_psw", bus.status, 4'h2);
        occ("push1", 1'b0, 1'b0);
        bus.push = 1'b1; psw(4'h3);
        step();
        bus.push = 1'b1; psw(4'h4);
        step();
        occ("push3", 1'b0, 1'b0);
        bus.push = 1'b1;
        step();
        occ("push4", 1'b1, 1'b0);
        errs("push4", 1'b0, 1'b0);
        bus.push = 1'b1; psw(4'h5);
        step();
        occ("push5", 1'b1, 1'b0);
        errs("push5", 1'b1, 1'b0);
        chk("push5_status", bus.status, 4'h5);

        bus.pop = 1'b1;
        step();
        chk("pop1", bus.status, 4'h4);
        occ("pop1", 1'b0, 1'b0);
        bus.pop = 1'b1;
        step();
        chk("pop2", bus.status, 4'h3);
        bus.pop = 1'b1;
        step();
        chk("pop3", bus.status, 4'h2);
        bus.pop = 1'b1;
        step();
        chk("pop4", bus.status, 4'h1);
        occ("pop4", 1'b0, 1'b1);
        bus.pop = 1'b1;
        step();
        chk("pop5_status", bus.status, 4'h1);
        errs("pop5", 1'b1, 1'b1);

        bus.err_clr = 1'b1;
        step();
        errs("clr", 1'b0, 1'b0);

        // push+pop together: both rejected, occupancy kept
        bus.push = 1'b1;
        step();
        psw(4'h6);
        step();
        bus.push = 1'b1; bus.pop = 1'b1;
        step();
        chk("pp_status", bus.status, 4'h6);
        errs("pp", 1'b1, 1'b1);
        occ("pp", 1'b0, 1'b0);
        bus.pop = 1'b1; bus.err_clr = 1'b1;
        step();
        chk("pp_pop", bus.status, 4'h1);
        occ("pp_pop", 1'b0, 1'b1);
        errs("pp_clr", 1'b0, 1'b0);

        // empty pop: flag update still applies; new error beats err_clr
        bus.pop = 1'b1; bus.err_clr = 1'b1;
        alu(OP_ADD, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h2);
        step();
        chk("unf_flag_upd", bus.status, 4'h3);
        errs("unf_clr", 1'b0, 1'b1);

        bus.err_clr = 1'b1;
        psw(4'h7);
        step();
        bus.push = 1'b1; psw(4'h9);
        step();
        bus.push = 1'b1;
        step();
        psw(4'hA); bus.pop = 1'b1;
        alu(OP_ADD, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'hF);
        step();
        chk("prio_psw", bus.status, 4'hA);
        occ("prio", 1'b0, 1'b0);
        bus.pop = 1'b1;
        step();
        chk("prio_next_pop", bus.status, 4'h7);
        occ("prio_next", 1'b0, 1'b1);
        errs("prio", 1'b0, 1'b0);

        // asynchronous reset mid-sequence
        bus.push = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        occ("pre_rst", 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_status", bus.status, 4'h0);
        occ("async", 1'b0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.pop = 1'b1;
        step();
        chk("post_rst_pop", bus.status, 4'h0);
        errs("post_rst", 1'b0, 1'b1);
        occ("post_rst", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 Parameter WORD_W, default 16, datapath word width in bits.
REQ-002 Parameter SHADOW_DEPTH, default 4, number of save/restore entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 flag_upd  in  1  strobe; compute flags from this cycle's ALU operands and result.
REQ-006 flag_mask  in  4  per-flag update enable, bit order {V,N,Z,C} (bit0=C, bit1=Z, bit2=N, bit3=V).
REQ-007 op_class  in  2  0=ADD, 1=SUB, 2=LOGIC, 3=SHIFT.
REQ-008 byte_mode  in  1  1 = flags evaluated on bits [7:0], else [WORD_W-1:0].
REQ-009 op_a, op_b, result  in  WORD_W each  ALU operands and result.
REQ-010 alu_carry  in  1  adder carry-out at the active width boundary (SUB: 1 = no borrow).
REQ-011 shift_out  in  1  last bit shifted out.
REQ-012 psw_wr  in  1  direct status load strobe; psw_wdata  in  4  value to load.
REQ-013 push, pop  in  1 each  save current status to / restore status from the shadow stack.
REQ-014 err_clr  in  1  clears sticky error flags.
REQ-015 status  out  4  registered flags {V,N,Z,C}, consumed by branch-condition logic.
REQ-016 shadow_full, shadow_empty  out  1 each  shadow stack occupancy.
REQ-017 err_ovf, err_unf  out  1 each  sticky push-when-full / pop-when-empty indicators.

Function
REQ-018 All status effects appear on status exactly one clock after the strobe cycle; status is never combinationally dependent on inputs.
REQ-019 N = MSB of active-width result; Z = 1 iff active-width result is all zeros.
REQ-020 ADD: C = alu_carry; V = (a_msb == b_msb) && (r_msb != a_msb).
REQ-021 SUB (a-b): C = alu_carry; V = (a_msb != b_msb) && (r_msb != a_msb).
REQ-022 LOGIC: C and V hold their current values regardless of flag_mask.
REQ-023 SHIFT: C = shift_out; V = 0.
REQ-024 On flag_upd, only flags with flag_mask bit set change; others hold.
REQ-025 Same-cycle write priority on status: psw_wr > pop > flag_upd; lower-priority sources are discarded that cycle.
REQ-026 push stores the pre-edge value of status; a concurrent flag_upd or psw_wr still updates status.
REQ-027 Shadow stack is LIFO; push increments occupancy, pop decrements it and loads the top entry into status.
REQ-028 push while full: no storage change, err_ovf set; pop while empty: status unaffected by pop (lower-priority flag_upd applies), err_unf set.
REQ-029 push and pop in the same cycle: both ignored, occupancy unchanged, err_ovf and err_unf both set.
REQ-030 err_clr clears both sticky flags; a same-cycle new error wins (flag stays set).
REQ-031 shadow_full = occupancy == SHADOW_DEPTH; shadow_empty = occupancy == 0; both registered-derived.

Reset
REQ-032 While rst_n low: status = 4'b0000, occupancy = 0, shadow_empty = 1, shadow_full = 0, err_ovf = err_unf = 0; shadow contents need not be cleared.
REQ-033 Reset asserted mid-sequence discards all pending pushes; first post-reset pop is an underflow.

Structure
REQ-034 Shared package holds flag bit-index constants (C=0, Z=1, N=2, V=3) and the op_class enumeration, also used by branch logic.
REQ-035 The shadow stack is a sub-module named status_shadow_stack (push/pop/data/full/empty/ovf/unf); flag computation stays in the top.

Verification
REQ-036 ADD word, a=16'h7FFF, b=16'h0001, r=16'h8000, carry=0, mask=4'hF -> next cycle status = {V=1,N=1,Z=0,C=0}.
REQ-037 SUB byte, a=8'h05, b=8'h05, r=16'hAB00, carry=1, mask=4'hF -> status = {0,0,1,1} (upper byte ignored).
REQ-038 status=4'b1011, LOGIC r=16'h0000, mask=4'hF -> status = 4'b1011 with Z=1, N=0 (C,V held) = 4'b1011.
REQ-039 Push 4 distinct values (1,2,3,4) then 5th push -> shadow_full=1, err_ovf=1; 4 pops restore 4,3,2,1; 5th pop -> err_unf=1, status unchanged.
REQ-040 psw_wr=1 (wdata=4'hA), pop=1, flag_upd=1 same cycle -> status=4'hA, occupancy decremented.
REQ-041 rst_n low asynchronously between edges with occupancy=3 -> status=0, shadow_empty=1 immediately, without waiting for clk.
